pixie_frame_store: RTL
======================

Name: pixie_frame_store

Overview:
- Parametrised single-clock successor to the Pixie dual-port frame buffer.
- CPU/DMA side writes pixel bytes; the Pixie scan-out side reads them with one-cycle registered latency.
- Adds a hardware clear engine (fills the buffer with a constant) and optional double buffering with frame-synchronous bank swap.
- Sits between the 1861 DMA capture logic and the video scan-out/scaler.

Parameters:
- DATA_W, 8, pixel byte width.
- ADDR_W, 10, address width on both ports.
- DEPTH, 512, words per bank. Must satisfy DEPTH <= 2**ADDR_W; non-power-of-two allowed.
- CLEAR_VAL, 0, value written by the clear engine.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write accepted this cycle (low while clearing).
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data valid (rd_en delayed one cycle).
- clear_req  in  1  single-cycle pulse: start clearing the write-side bank.
- clear_busy  out  1  clear engine active.
- swap_req  in  1  single-cycle pulse at end of frame: request bank swap.
- active_bank  out  1  bank currently read by scan-out.

Behaviour:
- Reset: synchronous, active-high; one clock, one reset (clk, reset).
- Reset values: rd_data=0, rd_valid=0, clear_busy=0, active_bank=0, swap pending=0, FSM=IDLE, wr_ready=1 after reset deasserts. RAM contents are not reset.
- Write: committed on the rising edge where wr_en && wr_ready. Writes with wr_addr >= DEPTH are dropped silently.
- Read latency: rd_en at cycle N gives rd_data and rd_valid=1 at N+1. rd_addr >= DEPTH returns 0. With rd_en=0, rd_data holds its last value and rd_valid=0.
- Read/write collision (same bank, same address, same cycle): read returns old data (read-before-write).
- FSM states:
  - IDLE -> CLEAR on clear_req.
  - CLEAR: counter runs 0..DEPTH-1, writes CLEAR_VAL once per cycle, clear_busy=1, wr_ready=0.
  - CLEAR -> IDLE on the cycle after the DEPTH-1 write. clear_busy is high for exactly DEPTH cycles.
- clear_req while in CLEAR is ignored (no restart).
- Reads are permitted during CLEAR. A read sees either old data or CLEAR_VAL, depending on whether the counter has passed that address.
- Reset mid-clear aborts immediately: next cycle FSM=IDLE, clear_busy=0; partially cleared contents remain.
- Simultaneous clear_req and wr_en in IDLE: the clear starts, and the write that cycle is still accepted (wr_ready is combinationally 1 in IDLE).

Optional Feature:
- Macro PIXIE_FB_DOUBLE_BUF_EN.
- Defined:
  - Two banks of DEPTH words.
  - Reads use bank active_bank; writes and clears target bank ~active_bank.
  - swap_req sets a pending flag. Swap (active_bank toggles) happens on the first cycle the pending flag is set and FSM=IDLE, then the flag clears.
  - A swap requested during CLEAR is deferred until the clear completes.
  - Multiple swap_req pulses before the swap executes collapse into one.
- Undefined:
  - Single bank, shared by reads, writes and clears.
  - swap_req is ignored; active_bank is tied to 0.

Decomposition:
- Shared package pixie_pkg: fb_state_t enum (FB_IDLE, FB_CLEAR) and default constants PIXIE_FB_DEPTH=512, PIXIE_FB_ADDR_W=10, PIXIE_FB_DATA_W=8.
- One sub-module, pixie_fb_bank: simple one-read/one-write synchronous RAM (registered read, read-before-write, enables).
  - Instantiated once, or twice under the macro.
  - Top level holds the FSM, clear counter, swap logic and address range checks.

Test Plan:
- Reset, write 0xA5 to addr 3, read addr 3 -> rd_data=0xA5 with rd_valid=1 exactly one cycle after rd_en.
- Write 0x11 to addr 7 and read addr 7 in the same cycle (prior value 0x22) -> read returns 0x22; the following read returns 0x11.
- Write addr 600 with DEPTH=512 -> write dropped; read addr 600 -> 0.
- clear_req with CLEAR_VAL=0xFF -> clear_busy high 512 cycles, wr_ready low throughout. Then read 0, 255 and 511 -> 0xFF. A wr_en held during the clear is accepted only once wr_ready returns high.
- Reset asserted 100 cycles into a clear -> clear_busy=0 next cycle; addr 50 reads CLEAR_VAL, addr 300 keeps its old value.
- With PIXIE_FB_DOUBLE_BUF_EN:
  - Write 0x33 to addr 0, then swap_req -> active_bank=1 and read addr 0 returns 0x33.
  - swap_req during a clear -> active_bank toggles only on the cycle after clear_busy falls.

Source files
------------

// File: rtl/pixie_pkg.sv
// Shared types and default sizing for the Pixie frame store.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pixie_pkg;

    typedef enum logic [0:0] {
        FB_IDLE  = 1'b0,
        FB_CLEAR = 1'b1
    } fb_state_t;

    localparam int PIXIE_FB_DEPTH  = 512;
    localparam int PIXIE_FB_ADDR_W = 10;
    localparam int PIXIE_FB_DATA_W = 8;

    // Index width needed to address 'depth' words inside one bank (never zero).
    function automatic int fb_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pixie_fb_bank.sv
// One-read/one-write synchronous RAM bank; read-before-write on address collision.
// Latency: read data registered, valid the cycle after rd_en.
// Backpressure: none; both ports accept every cycle, rd_data holds when rd_en is low.
module pixie_fb_bank
    import pixie_pkg::*;
#(
    parameter int DATA_W = PIXIE_FB_DATA_W,
    parameter int DEPTH  = PIXIE_FB_DEPTH,
    parameter int IDX_W  = fb_idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array: contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; sampling the array before the write lands gives old data on collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixie_frame_store.sv
// Pixel frame store with hardware clear engine; optional double buffering under PIXIE_FB_DOUBLE_BUF_EN.
// Latency: rd_en at cycle N gives rd_data/rd_valid at N+1; writes commit on the accepting edge.
// Backpressure: wr_ready drops for exactly DEPTH cycles while clearing; reads are never stalled.
module pixie_frame_store
    import pixie_pkg::*;
#(
    parameter int                DATA_W    = PIXIE_FB_DATA_W,
    parameter int                ADDR_W    = PIXIE_FB_ADDR_W,
    parameter int                DEPTH     = PIXIE_FB_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              swap_req,
    output logic              active_bank
);

    localparam int                IW       = fb_idx_w(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IW-1:0]     LAST_IDX = IW'(DEPTH - 1);

    fb_state_t         state_q;
    fb_state_t         state_d;
    logic [IW-1:0]     clr_cnt_q;

    logic              wr_in_rng;
    logic              rd_in_rng;
    logic              rd_go;

    logic              bank_we;
    logic [IW-1:0]     bank_wa;
    logic [DATA_W-1:0] bank_wd;

    logic              rd_oor_q;
    logic              rd_sel_q;
    logic [DATA_W-1:0] rd_bank_dat;

    // Addresses past the end of a bank are dropped on write and read back as zero.
    assign wr_in_rng = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_rng = ({1'b0, rd_addr} < DEPTH_L);
    assign rd_go     = rd_en && rd_in_rng;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear_req only starts a clear from IDLE, so a repeat pulse never restarts it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FB_IDLE:  if (clear_req)             state_d = FB_CLEAR;
            FB_CLEAR: if (clr_cnt_q == LAST_IDX) state_d = FB_IDLE;
            default:                             state_d = FB_IDLE;
        endcase
    end

    // FSM outputs: the clear engine owns the write port while active, otherwise the user write passes through.
    always_comb begin
        clear_busy = 1'b0;
        wr_ready   = 1'b1;
        bank_we    = wr_en && wr_in_rng;
        bank_wa    = wr_addr[IW-1:0];
        bank_wd    = wr_data;
        if (state_q == FB_CLEAR) begin
            clear_busy = 1'b1;
            wr_ready   = 1'b0;
            bank_we    = 1'b1;
            bank_wa    = clr_cnt_q;
            bank_wd    = CLEAR_VAL;
        end
    end

    // Clear address counter: sweeps 0..DEPTH-1 during CLEAR and parks at 0 otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt_q <= '0;
        end else if (state_q == FB_CLEAR && clr_cnt_q != LAST_IDX) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end else begin
            clr_cnt_q <= '0;
        end
    end

    // Read sideband: valid strobe, out-of-range flag and bank select, all captured alongside the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_oor_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_oor_q <= ~rd_in_rng;
                rd_sel_q <= active_bank;
            end
        end
    end

`ifdef PIXIE_FB_DOUBLE_BUF_EN
    logic              swap_pend_q;
    logic              act_q;
    logic              do_swap;
    logic [DATA_W-1:0] rd_q0;
    logic [DATA_W-1:0] rd_q1;

    // A pending swap waits for the clear engine to finish so scan-out never sees a half-cleared frame.
    assign do_swap     = swap_pend_q && (state_q == FB_IDLE);
    assign active_bank = act_q;

    // Swap bookkeeping: pulses arriving before or with the executing swap collapse into it.
    always_ff @(posedge clk) begin
        if (reset) begin
            swap_pend_q <= 1'b0;
            act_q       <= 1'b0;
        end else begin
            swap_pend_q <= do_swap ? 1'b0 : (swap_pend_q | swap_req);
            if (do_swap) begin
                act_q <= ~act_q;
            end
        end
    end

    // Scan-out reads bank act_q; writes and clears go to the other bank.
    pixie_fb_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IW)
    ) u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bank_we && act_q),
        .wr_addr (bank_wa),
        .wr_data (bank_wd),
        .rd_en   (rd_go && !act_q),
        .rd_addr (rd_addr[IW-1:0]),
        .rd_data (rd_q0)
    );

    pixie_fb_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IW)
    ) u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bank_we && !act_q),
        .wr_addr (bank_wa),
        .wr_data (bank_wd),
        .rd_en   (rd_go && act_q),
        .rd_addr (rd_addr[IW-1:0]),
        .rd_data (rd_q1)
    );

    assign rd_bank_dat = rd_sel_q ? rd_q1 : rd_q0;
`else
    logic unused_single_bank;

    // Single bank: no swapping, scan-out always reads bank 0.
    assign active_bank        = 1'b0;
    assign unused_single_bank = swap_req ^ rd_sel_q;

    pixie_fb_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IW)
    ) u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bank_we),
        .wr_addr (bank_wa),
        .wr_data (bank_wd),
        .rd_en   (rd_go),
        .rd_addr (rd_addr[IW-1:0]),
        .rd_data (rd_bank_dat)
    );
`endif

    assign rd_data = rd_oor_q ? '0 : rd_bank_dat;

endmodule
